// File: rtl/hazard_ctrl_mc_pkg.sv
// Shared definitions for the multi-cycle hazard controller: defaults, load FSM
// encoding and the hazard class reported each cycle.
package hazard_ctrl_mc_pkg;

  localparam int REG_AW_DEF = 5;

  typedef enum logic {
    RUN     = 1'b0,
    LD_WAIT = 1'b1
  } ld_state_e;

  // Exactly one class is active per cycle; FREEZE outranks STALL outranks FLUSH.
  typedef enum logic [1:0] {
    HZ_NONE   = 2'd0,
    HZ_FREEZE = 2'd1,
    HZ_STALL  = 2'd2,
    HZ_FLUSH  = 2'd3
  } hz_class_e;

endpackage

// File: rtl/hazard_ctrl_mc_mdu.sv
// Multiply/divide occupancy tracker: reloads on issue, counts down while the
// pipeline is not frozen, and reports busy while any occupancy remains.
module hazard_mdu_tracker #(
  parameter int MDU_LAT = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic freeze,
  input  logic issue,
  output logic busy
);

  localparam int CW = $clog2(MDU_LAT + 1);

  logic [CW-1:0] mdu_cnt;

  // A start blocked by busy never reaches here, so issue is a clean reload.
  always_ff @(posedge clk) begin
    if (reset) begin
      mdu_cnt <= '0;
    end else if (!freeze) begin
      if (issue) begin
        mdu_cnt <= CW'(MDU_LAT);
      end else if (mdu_cnt != '0) begin
        mdu_cnt <= mdu_cnt - CW'(1);
      end
    end
  end

  assign busy = (mdu_cnt != '0);

endmodule

// File: rtl/hazard_ctrl_mc.sv
// Hazard controller beside the ID stage: resolves load-use, branch-operand,
// multi-cycle load and MDU hazards into stall/flush/freeze controls.
module hazard_ctrl_mc
  import hazard_ctrl_mc_pkg::*;
#(
  parameter int REG_AW   = REG_AW_DEF,
  parameter int LOAD_LAT = 1,
  parameter int MDU_LAT  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_is_branch,
  input  logic              id_is_jump,
  input  logic              id_br_taken,
  input  logic              id_mdu_start,
  input  logic              id_mdu_read,
  input  logic              ex_reg_write,
  input  logic              ex_mem_rd,
  input  logic [REG_AW-1:0] ex_wr_reg,
  input  logic              mem_mem_rd,
  input  logic [REG_AW-1:0] mem_wr_reg,
  input  logic              mem_wait,
  output logic              pc_stall,
  output logic              if_id_stall,
  output logic              if_id_flush,
  output logic              id_ex_stall,
  output logic              id_ex_flush,
  output logic              ex_mem_stall,
  output logic              mdu_busy
);

  localparam int LD_W = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;

  ld_state_e   state, state_nxt;
  logic [LD_W-1:0] ld_cnt, ld_cnt_nxt;
  hz_class_e   hz_class;

  logic hit_ex, hit_mem;
  logic lu, br_ex, br_mem, ldw, mdu_hz;
  logic stall_req, flush_req;
  logic busy_raw, mdu_issue;

  // Register $0 is hardwired, so it never creates a dependency.
  function automatic logic hz_match(
    input logic [REG_AW-1:0] r,
    input logic [REG_AW-1:0] rs,
    input logic [REG_AW-1:0] rt,
    input logic              use_rs,
    input logic              use_rt
  );
    return (r != '0) && ((use_rs && (rs == r)) || (use_rt && (rt == r)));
  endfunction

  assign hit_ex  = hz_match(ex_wr_reg,  id_rs, id_rt, id_uses_rs, id_uses_rt);
  assign hit_mem = hz_match(mem_wr_reg, id_rs, id_rt, id_uses_rs, id_uses_rt);

  assign lu     = ex_mem_rd & hit_ex;
  assign br_ex  = id_is_branch & ex_reg_write & hit_ex;
  assign br_mem = id_is_branch & mem_mem_rd & hit_mem;
  assign ldw    = (state == LD_WAIT) & hit_mem;
  assign mdu_hz = busy_raw & (id_mdu_start | id_mdu_read);

  assign stall_req = lu | br_ex | br_mem | ldw | mdu_hz;
  assign flush_req = id_is_jump | (id_is_branch & id_br_taken);

  always_comb begin
    hz_class = HZ_NONE;
    if (reset) begin
      hz_class = HZ_NONE;
    end else if (mem_wait) begin
      hz_class = HZ_FREEZE;
    end else if (stall_req) begin
      hz_class = HZ_STALL;
    end else if (flush_req) begin
      hz_class = HZ_FLUSH;
    end
  end

  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_stall = 1'b0;
    case (hz_class)
      HZ_FREEZE: begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_stall  = 1'b1;
        ex_mem_stall = 1'b1;
      end
      HZ_STALL: begin
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        id_ex_flush = 1'b1;
      end
      HZ_FLUSH: begin
        if_id_flush = 1'b1;
      end
      default: ;
    endcase
  end

  assign mdu_busy  = busy_raw & ~reset;
  assign mdu_issue = id_mdu_start & ~stall_req & ~mem_wait;

  hazard_mdu_tracker #(
    .MDU_LAT (MDU_LAT)
  ) u_mdu (
    .clk    (clk),
    .reset  (reset),
    .freeze (mem_wait),
    .issue  (mdu_issue),
    .busy   (busy_raw)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= RUN;
      ld_cnt <= '0;
    end else begin
      state  <= state_nxt;
      ld_cnt <= ld_cnt_nxt;
    end
  end

  // The load enters LD_WAIT as it leaves EX; ld_cnt counts the remaining MEM cycles.
  always_comb begin
    state_nxt  = state;
    ld_cnt_nxt = ld_cnt;
    if (!mem_wait) begin
      case (state)
        RUN: begin
          if ((LOAD_LAT > 1) && lu) begin
            state_nxt  = LD_WAIT;
            ld_cnt_nxt = LD_W'(LOAD_LAT - 1);
          end
        end
        LD_WAIT: begin
          ld_cnt_nxt = ld_cnt - LD_W'(1);
          if (ld_cnt == LD_W'(1)) begin
            state_nxt = RUN;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Bench for hazard_ctrl_mc: two instances (LOAD_LAT 1 and 3, MDU_LAT 4) share
// stimulus; an abstract per-cycle model plus directed literal expectations.
module tb_hazard_ctrl_mc;

  localparam int AW = 5;
  localparam int MLAT = 4;
  localparam logic [6:0] O_STALL  = 7'b1100100;
  localparam logic [6:0] O_FREEZE = 7'b1101010;
  localparam logic [6:0] O_FLUSH  = 7'b0010000;

  logic clk = 1'b0;
  logic reset;
  logic [AW-1:0] id_rs, id_rt, ex_wr_reg, mem_wr_reg;
  logic id_uses_rs, id_uses_rt, id_is_branch, id_is_jump, id_br_taken;
  logic id_mdu_start, id_mdu_read, ex_reg_write, ex_mem_rd, mem_mem_rd, mem_wait;

  logic [6:0] outs_a, outs_b;

  int n_checks = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_ctrl_mc #(.REG_AW(AW), .LOAD_LAT(1), .MDU_LAT(MLAT)) dut_a (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_is_branch(id_is_branch), .id_is_jump(id_is_jump), .id_br_taken(id_br_taken),
    .id_mdu_start(id_mdu_start), .id_mdu_read(id_mdu_read),
    .ex_reg_write(ex_reg_write), .ex_mem_rd(ex_mem_rd), .ex_wr_reg(ex_wr_reg),
    .mem_mem_rd(mem_mem_rd), .mem_wr_reg(mem_wr_reg), .mem_wait(mem_wait),
    .pc_stall(outs_a[6]), .if_id_stall(outs_a[5]), .if_id_flush(outs_a[4]),
    .id_ex_stall(outs_a[3]), .id_ex_flush(outs_a[2]), .ex_mem_stall(outs_a[1]),
    .mdu_busy(outs_a[0])
  );

  hazard_ctrl_mc #(.REG_AW(AW), .LOAD_LAT(3), .MDU_LAT(MLAT)) dut_b (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_is_branch(id_is_branch), .id_is_jump(id_is_jump), .id_br_taken(id_br_taken),
    .id_mdu_start(id_mdu_start), .id_mdu_read(id_mdu_read),
    .ex_reg_write(ex_reg_write), .ex_mem_rd(ex_mem_rd), .ex_wr_reg(ex_wr_reg),
    .mem_mem_rd(mem_mem_rd), .mem_wr_reg(mem_wr_reg), .mem_wait(mem_wait),
    .pc_stall(outs_b[6]), .if_id_stall(outs_b[5]), .if_id_flush(outs_b[4]),
    .id_ex_stall(outs_b[3]), .id_ex_flush(outs_b[2]), .ex_mem_stall(outs_b[1]),
    .mdu_busy(outs_b[0])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit dep(input logic [AW-1:0] r);
    return (r != 0) && ((id_uses_rs && id_rs == r) || (id_uses_rt && id_rt == r));
  endfunction

  // Behavioural model: remaining load-wait cycles and remaining MDU occupancy.
  int ld_rem[2];
  int mdu_rem[2];
  int ld_nxt[2];
  int mdu_nxt[2];

  initial begin
    ld_rem = '{0, 0};
    mdu_rem = '{0, 0};
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        int lat;
        bit stall, flush, busy;
        logic [6:0] e;
        lat = (k == 0) ? 1 : 3;
        busy = mdu_rem[k] > 0;
        stall = (ex_mem_rd && dep(ex_wr_reg))
             || (id_is_branch && ex_reg_write && dep(ex_wr_reg))
             || (id_is_branch && mem_mem_rd && dep(mem_wr_reg))
             || (ld_rem[k] > 0 && dep(mem_wr_reg))
             || (busy && (id_mdu_start || id_mdu_read));
        flush = id_is_jump || (id_is_branch && id_br_taken);
        if (reset) e = 7'b0;
        else if (mem_wait) e = O_FREEZE | {6'b0, busy};
        else if (stall) e = O_STALL | {6'b0, busy};
        else if (flush) e = O_FLUSH | {6'b0, busy};
        else e = {6'b0, busy};
        chk(k == 0 ? "model_lat1" : "model_lat3", {25'b0, (k == 0) ? outs_a : outs_b}, {25'b0, e});
        ld_nxt[k] = ld_rem[k];
        mdu_nxt[k] = mdu_rem[k];
        if (reset) begin
          ld_nxt[k] = 0;
          mdu_nxt[k] = 0;
        end else if (!mem_wait) begin
          if (ld_rem[k] > 0) ld_nxt[k] = ld_rem[k] - 1;
          else if (lat > 1 && ex_mem_rd && dep(ex_wr_reg)) ld_nxt[k] = lat - 1;
          if (id_mdu_start && !stall) mdu_nxt[k] = MLAT;
          else if (mdu_rem[k] > 0) mdu_nxt[k] = mdu_rem[k] - 1;
        end
      end
      @(posedge clk);
      ld_rem = ld_nxt;
      mdu_rem = mdu_nxt;
    end
  end

  task automatic clear_in();
    id_rs = '0; id_rt = '0; ex_wr_reg = '0; mem_wr_reg = '0;
    id_uses_rs = 0; id_uses_rt = 0; id_is_branch = 0; id_is_jump = 0; id_br_taken = 0;
    id_mdu_start = 0; id_mdu_read = 0; ex_reg_write = 0; ex_mem_rd = 0;
    mem_mem_rd = 0; mem_wait = 0;
  endtask

  task automatic cyc(output logic [6:0] a, output logic [6:0] b);
    @(negedge clk);
    a = outs_a;
    b = outs_b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    logic [6:0] a, b;
    for (int i = 0; i < n; i++) cyc(a, b);
  endtask

  initial begin
    logic [6:0] a, b;
    int n_st, n_fz;
    clear_in();
    reset = 1;
    mem_wait = 1; id_mdu_read = 1; id_is_jump = 1;
    cyc(a, b); chk("reset_out_a", {25'b0, a}, 0); chk("reset_out_b", {25'b0, b}, 0);
    cyc(a, b);
    clear_in(); reset = 0;

    // lw $2 in EX, add $3,$2,$4 in ID
    ex_mem_rd = 1; ex_reg_write = 1; ex_wr_reg = 2;
    id_rs = 2; id_uses_rs = 1; id_rt = 4; id_uses_rt = 1;
    cyc(a, b); chk("t1_lu_stall", {25'b0, a}, {25'b0, O_STALL});
    ex_mem_rd = 0; ex_reg_write = 0; ex_wr_reg = 0; mem_mem_rd = 1; mem_wr_reg = 2;
    cyc(a, b); chk("t1_release", {25'b0, a}, 0);
    clear_in(); idle(4);

    // lw $0 is never a hazard
    ex_mem_rd = 1; ex_reg_write = 1; ex_wr_reg = 0; id_rs = 0; id_uses_rs = 1;
    cyc(a, b); chk("t2_r0_a", {25'b0, a}, 0); chk("t2_r0_b", {25'b0, b}, 0);
    clear_in();

    // LOAD_LAT=3: lw $5 then use $5
    n_st = 0;
    ex_mem_rd = 1; ex_reg_write = 1; ex_wr_reg = 5; id_rt = 5; id_uses_rt = 1;
    cyc(a, b); n_st += b[6];
    ex_mem_rd = 0; ex_reg_write = 0; ex_wr_reg = 0; mem_mem_rd = 1; mem_wr_reg = 5;
    for (int i = 0; i < 4; i++) begin cyc(a, b); n_st += b[6]; end
    chk("t2_lat3_stalls", n_st, 3);
    clear_in(); idle(2);

    // add $6 in EX, beq $6,$7 in ID
    ex_reg_write = 1; ex_wr_reg = 6;
    id_is_branch = 1; id_rs = 6; id_uses_rs = 1; id_rt = 7; id_uses_rt = 1;
    cyc(a, b); chk("t3_br_ex", {25'b0, a}, {25'b0, O_STALL});
    ex_reg_write = 0; ex_wr_reg = 0; mem_wr_reg = 6;
    cyc(a, b); chk("t3_br_ex_release", {25'b0, a}, 0);
    clear_in(); idle(2);

    // lw $6 in EX, beq $6 taken: two stalls with flush suppressed, then flush
    ex_mem_rd = 1; ex_reg_write = 1; ex_wr_reg = 6; id_br_taken = 1;
    id_is_branch = 1; id_rs = 6; id_uses_rs = 1; id_rt = 7; id_uses_rt = 1;
    cyc(a, b); chk("t3_lw_br_ex", {25'b0, a}, {25'b0, O_STALL});
    ex_mem_rd = 0; ex_reg_write = 0; ex_wr_reg = 0; mem_mem_rd = 1; mem_wr_reg = 6;
    cyc(a, b); chk("t3_lw_br_mem", {25'b0, a}, {25'b0, O_STALL});
    mem_mem_rd = 0; mem_wr_reg = 0;
    cyc(a, b); chk("t3_taken_flush", {25'b0, a}, {25'b0, O_FLUSH});
    clear_in(); idle(4);

    // jr $3 while lw $3 in EX
    ex_mem_rd = 1; ex_reg_write = 1; ex_wr_reg = 3; id_is_jump = 1; id_rs = 3; id_uses_rs = 1;
    cyc(a, b); chk("t4_jump_lu", {25'b0, a}, {25'b0, O_STALL});
    ex_mem_rd = 0; ex_reg_write = 0; ex_wr_reg = 0;
    cyc(a, b); chk("t4_jump_flush", {25'b0, a}, {25'b0, O_FLUSH});
    clear_in(); idle(2);

    // mult issues, nop, then mflo waits for the MDU
    id_mdu_start = 1;
    cyc(a, b); chk("t5_mult_issue", {25'b0, a}, 0);
    clear_in();
    cyc(a, b); chk("t5_busy", {25'b0, a}, 1);
    id_mdu_read = 1; n_st = 0;
    for (int i = 0; i < 5; i++) begin cyc(a, b); n_st += a[6]; end
    chk("t5_mflo_stalls", n_st, 3);
    chk("t5_mflo_issue", {25'b0, a}, 0);
    clear_in(); idle(1);

    // memory wait during LD_WAIT holds the load counter
    n_st = 0; n_fz = 0;
    ex_mem_rd = 1; ex_reg_write = 1; ex_wr_reg = 5; id_rt = 5; id_uses_rt = 1;
    cyc(a, b);
    ex_mem_rd = 0; ex_reg_write = 0; ex_wr_reg = 0; mem_mem_rd = 1; mem_wr_reg = 5; mem_wait = 1;
    cyc(a, b); chk("t6_freeze", {25'b0, b}, {25'b0, O_FREEZE}); n_fz += b[1];
    cyc(a, b); n_fz += b[1];
    mem_wait = 0;
    for (int i = 0; i < 4; i++) begin cyc(a, b); n_st += (b[6] & ~b[1]); end
    chk("t6_freeze_cycles", n_fz, 2);
    chk("t6_post_freeze_stalls", n_st, 2);
    clear_in(); idle(1);

    // reset in the middle of MDU occupancy
    id_mdu_start = 1;
    cyc(a, b);
    clear_in();
    cyc(a, b); chk("t6_busy_before_reset", {25'b0, a}, 1);
    reset = 1;
    cyc(a, b); chk("t6_reset_out", {25'b0, a}, 0);
    reset = 0;
    cyc(a, b); chk("t6_mdu_cleared", {25'b0, a}, 0);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      id_rs = AW'($urandom_range(0, 3)); id_rt = AW'($urandom_range(0, 3));
      ex_wr_reg = AW'($urandom_range(0, 3)); mem_wr_reg = AW'($urandom_range(0, 3));
      id_uses_rs = ($urandom_range(0, 3) != 0); id_uses_rt = ($urandom_range(0, 1) != 0);
      id_is_branch = ($urandom_range(0, 3) == 0); id_is_jump = ($urandom_range(0, 7) == 0);
      id_br_taken = ($urandom_range(0, 1) != 0);
      id_mdu_start = ($urandom_range(0, 9) == 0); id_mdu_read = ($urandom_range(0, 6) == 0);
      ex_reg_write = ($urandom_range(0, 1) != 0); ex_mem_rd = ($urandom_range(0, 2) == 0);
      mem_mem_rd = ($urandom_range(0, 2) == 0); mem_wait = ($urandom_range(0, 11) == 0);
      reset = ($urandom_range(0, 63) == 0);
      cyc(a, b);
    end
    reset = 0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
